// File: rtl/dct_sched_pkg.sv
// Shared sizing and index types for the dct_block row MAC scheduler.
package dct_sched_pkg;

   localparam int DEF_N_TAPS = 8;
   localparam int DEF_N_ROWS = 8;
   localparam int DEF_TAP_W  = $clog2(DEF_N_TAPS);
   localparam int DEF_ROW_W  = $clog2(DEF_N_ROWS);

   typedef logic [DEF_TAP_W-1:0] tap_idx_t;
   typedef logic [DEF_ROW_W-1:0] row_idx_t;

endpackage

// File: rtl/dct_mac_sched.sv
// Sequencer for one row of eight macu units: accumulate stage feeding a
// one-deep result-hold slot drained through a valid/ready handshake.
module dct_mac_sched
   import dct_sched_pkg::*;
#(
   parameter int N_TAPS = DEF_N_TAPS,
   parameter int N_ROWS = DEF_N_ROWS,
   parameter int TAP_W  = $clog2(N_TAPS),
   parameter int ROW_W  = $clog2(N_ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             mac_en,
   output logic             mac_clr,
   output logic [TAP_W-1:0] coef_idx,
   output logic             res_ld,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [ROW_W-1:0] dout_row,
   output logic             blk_done
);

   logic [TAP_W-1:0] tap_cnt;
   logic             acc_done;
   logic             res_full;
   logic [ROW_W-1:0] row_cnt;
   logic             blk_done_q;
   logic             dout_take;

   // A finished group stalls input until the result slot can accept it.
   assign din_ready  = ena & ~acc_done;
   assign mac_en     = din_valid & din_ready;
   assign mac_clr    = mac_en & (tap_cnt == TAP_W'(0));
   assign coef_idx   = tap_cnt;
   assign dout_take  = res_full & dout_ready & ena;
   assign res_ld     = ena & acc_done & (~res_full | dout_take);

   assign dout_valid = res_full;
   assign dout_row   = row_cnt;
   assign blk_done   = blk_done_q;

   // Accumulate side: tap counter and group-complete flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tap_cnt  <= TAP_W'(0);
         acc_done <= 1'b0;
      end else if (ena) begin
         if (mac_en) begin
            tap_cnt <= tap_cnt + TAP_W'(1);
            if (tap_cnt == TAP_W'(N_TAPS - 1)) begin
               acc_done <= 1'b1;
            end
         end else if (res_ld) begin
            acc_done <= 1'b0;
         end
      end
   end

   // Result side: a load in the drain cycle keeps the slot full.
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_full   <= 1'b0;
         row_cnt    <= ROW_W'(0);
         blk_done_q <= 1'b0;
      end else if (ena) begin
         if (res_ld) begin
            res_full <= 1'b1;
         end else if (dout_take) begin
            res_full <= 1'b0;
         end
         if (dout_take) begin
            row_cnt <= row_cnt + ROW_W'(1);
         end
         blk_done_q <= dout_take & (row_cnt == ROW_W'(N_ROWS - 1));
      end
   end

endmodule

// File: tb/tb_dct_mac_sched.sv
// Directed and randomised checks of the dct_mac_sched row sequencer.
module tb_dct_mac_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic       mac_en;
   logic       mac_clr;
   logic [2:0] coef_idx;
   logic       res_ld;
   logic       dout_valid;
   logic       dout_ready = 1'b0;
   logic [2:0] dout_row;
   logic       blk_done;

   int n_vec = 0;
   int n_err = 0;
   int macs  = 0;
   int lds   = 0;
   int takes = 0;

   dct_mac_sched dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .coef_idx   (coef_idx),
      .res_ld     (res_ld),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_row   (dout_row),
      .blk_done   (blk_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 unit later.
   task automatic drive(input logic e, input logic dv, input logic dr);
      @(negedge clk);
      ena        = e;
      din_valid  = dv;
      dout_ready = dr;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; ena = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic score();
      if (!ena) chk("gated_outs", {31'd0, mac_en | res_ld | din_ready}, 32'd0);
      if (dout_valid && dout_ready && ena) begin
         chk("take_order", {31'd0, takes < lds}, 32'd1);
         chk("take_row", {29'd0, dout_row}, takes % 8);
         takes++;
      end
      if (res_ld) begin
         chk("ld_group", macs, 8 * (lds + 1));
         lds++;
      end
      if (mac_en) begin
         chk("rnd_coef", {29'd0, coef_idx}, macs % 8);
         chk("rnd_clr", {31'd0, mac_clr}, {31'd0, (macs % 8) == 0});
         macs++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
      chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_dout_row", {29'd0, dout_row}, 32'd0);
      chk("rst_blk_done", {31'd0, blk_done}, 32'd0);
      chk("rst_mac_en", {31'd0, mac_en}, 32'd0);
      chk("rst_res_ld", {31'd0, res_ld}, 32'd0);

      // First group of eight taps, then load and present
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         chk("t1_mac_en", {31'd0, mac_en}, 32'd1);
         chk("t1_mac_clr", {31'd0, mac_clr}, {31'd0, i == 0});
         chk("t1_coef", {29'd0, coef_idx}, i);
      end
      drive(1'b1, 1'b1, 1'b0);
      chk("t1_stall_ready", {31'd0, din_ready}, 32'd0);
      chk("t1_stall_mac", {31'd0, mac_en}, 32'd0);
      chk("t1_res_ld", {31'd0, res_ld}, 32'd1);
      chk("t1_dv_early", {31'd0, dout_valid}, 32'd0);

      // Second group arrives while the first row is held by backpressure
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         chk("t2_dout_valid", {31'd0, dout_valid}, 32'd1);
         chk("t2_dout_row", {29'd0, dout_row}, 32'd0);
         chk("t2_res_ld", {31'd0, res_ld}, 32'd0);
         chk("t2_mac_en", {31'd0, mac_en}, {31'd0, i < 8});
         if (i < 8) chk("t2_coef", {29'd0, coef_idx}, i);
      end
      drive(1'b1, 1'b0, 1'b1);
      chk("t2_ld_take", {31'd0, res_ld}, 32'd1);
      chk("t2_dv_take", {31'd0, dout_valid}, 32'd1);
      drive(1'b1, 1'b0, 1'b0);
      chk("t2_dv_after", {31'd0, dout_valid}, 32'd1);
      chk("t2_row_after", {29'd0, dout_row}, 32'd1);
      chk("t2_ready_after", {31'd0, din_ready}, 32'd1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      chk("t2_drained", {31'd0, dout_valid}, 32'd0);
      chk("t2_row2", {29'd0, dout_row}, 32'd2);

      // Full 8x8 block streamed with downstream always ready
      do_reset();
      for (int c = 0; c < 76; c++) begin
         drive(1'b1, c <= 70, 1'b1);
         chk("t3_mac_en", {31'd0, mac_en}, {31'd0, (c <= 70) && (c % 9 != 8)});
         chk("t3_res_ld", {31'd0, res_ld}, {31'd0, (c >= 8) && (c <= 71) && (c % 9 == 8)});
         chk("t3_dout_valid", {31'd0, dout_valid}, {31'd0, (c >= 9) && (c <= 72) && (c % 9 == 0)});
         chk("t3_blk_done", {31'd0, blk_done}, {31'd0, c == 73});
         if ((c <= 70) && (c % 9 != 8)) begin
            chk("t3_coef", {29'd0, coef_idx}, c % 9);
            chk("t3_clr", {31'd0, mac_clr}, {31'd0, c % 9 == 0});
         end
         if ((c >= 9) && (c % 9 == 0) && (c <= 72)) chk("t3_row", {29'd0, dout_row}, c / 9 - 1);
         if (c == 74) chk("t3_row_wrap", {29'd0, dout_row}, 32'd0);
      end

      // Clock-enable gaps mid-group and while a row is held
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1);
         chk("t4_gap_ready", {31'd0, din_ready}, 32'd0);
         chk("t4_gap_mac", {31'd0, mac_en}, 32'd0);
         chk("t4_gap_coef", {29'd0, coef_idx}, 32'd4);
      end
      for (int i = 4; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         chk("t4_resume_mac", {31'd0, mac_en}, 32'd1);
         chk("t4_resume_clr", {31'd0, mac_clr}, 32'd0);
         chk("t4_resume_coef", {29'd0, coef_idx}, i);
      end
      drive(1'b1, 1'b0, 1'b0);
      chk("t4_res_ld", {31'd0, res_ld}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1);
         chk("t4_hold_ld", {31'd0, res_ld}, 32'd0);
         chk("t4_hold_mac", {31'd0, mac_en}, 32'd0);
         chk("t4_hold_dv", {31'd0, dout_valid}, 32'd1);
         chk("t4_hold_row", {29'd0, dout_row}, 32'd0);
      end
      drive(1'b1, 1'b0, 1'b1);
      chk("t4_take_dv", {31'd0, dout_valid}, 32'd1);
      drive(1'b1, 1'b0, 1'b0);
      chk("t4_after_dv", {31'd0, dout_valid}, 32'd0);
      chk("t4_after_row", {29'd0, dout_row}, 32'd1);

      // Reset mid-group with a row held
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
      chk("t5_held", {31'd0, dout_valid}, 32'd1);
      do_reset();
      chk("t5_dv", {31'd0, dout_valid}, 32'd0);
      chk("t5_ready", {31'd0, din_ready}, 32'd1);
      chk("t5_row", {29'd0, dout_row}, 32'd0);
      drive(1'b1, 1'b1, 1'b0);
      chk("t5_clr", {31'd0, mac_clr}, 32'd1);
      chk("t5_coef", {29'd0, coef_idx}, 32'd0);

      // Random traffic with an ordering scoreboard
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
         score();
      end
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         score();
      end
      chk("rnd_lds", lds, macs / 8);
      chk("rnd_takes", takes, lds);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
